// File: rtl/mem_stage.sv
// Memory stage: runs load/store transactions over a req/ack handshake with a
// timeout, stalls upstream while pending, and holds the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadDataRF1,
  input  logic [4:0]  WriteRegister,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        misaligned_err,
  output logic        RegWriteWB,
  output logic        MemToRegWB,
  output logic [31:0] MemReadDataWB,
  output logic [31:0] ALUResultWB,
  output logic [4:0]  WriteRegisterWB
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       WAIT     = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             regWrite_q, regWrite_d;
  logic             memToReg_q, memToReg_d;
  logic [31:0]      readData_q, readData_d;
  logic [31:0]      aluResult_q, aluResult_d;
  logic [4:0]       writeReg_q, writeReg_d;
  logic             busErr_q, busErr_d;
  logic             misErr_q, misErr_d;

  logic access, aligned, isLoad, inWait, timeout, capture;

  assign access  = MemRead | MemWrite;
  assign aligned = (ALUResult[1:0] == 2'b00);
  assign isLoad  = MemRead & ~MemWrite;
  assign inWait  = (state_q == WAIT);
  assign timeout = inWait & (cnt_q == CNT_LAST);

  assign dmem_req   = (~inWait & access & aligned) | inWait;
  assign dmem_we    = MemWrite;
  assign dmem_addr  = ALUResult;
  assign dmem_wdata = ReadDataRF1;
  assign mem_stall  = dmem_req & ~dmem_ack & ~timeout;

  // The instruction retires into MEM/WB either as a non-memory op or on ack;
  // every other cycle inserts a bubble so write-back happens exactly once.
  assign capture = (~inWait & ~access) | (dmem_req & dmem_ack);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busErr_d = 1'b0;
    misErr_d = 1'b0;
    if (!inWait) begin
      cnt_d = '0;
      if (access && !aligned) begin
        misErr_d = 1'b1;
      end else if (access && !dmem_ack) begin
        state_d = WAIT;
      end
    end else if (dmem_ack) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (timeout) begin
      state_d  = IDLE;
      cnt_d    = '0;
      busErr_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    regWrite_d  = 1'b0;
    memToReg_d  = 1'b0;
    readData_d  = readData_q;
    aluResult_d = aluResult_q;
    writeReg_d  = writeReg_q;
    if (capture) begin
      regWrite_d  = RegWrite;
      memToReg_d  = MemToReg;
      aluResult_d = ALUResult;
      writeReg_d  = WriteRegister;
      if (isLoad) begin
        readData_d = dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      readData_q  <= '0;
      aluResult_q <= '0;
      writeReg_q  <= '0;
      busErr_q    <= 1'b0;
      misErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regWrite_q  <= regWrite_d;
      memToReg_q  <= memToReg_d;
      readData_q  <= readData_d;
      aluResult_q <= aluResult_d;
      writeReg_q  <= writeReg_d;
      busErr_q    <= busErr_d;
      misErr_q    <= misErr_d;
    end
  end

  assign RegWriteWB      = regWrite_q;
  assign MemToRegWB      = memToReg_q;
  assign MemReadDataWB   = readData_q;
  assign ALUResultWB     = aluResult_q;
  assign WriteRegisterWB = writeReg_q;
  assign bus_err         = busErr_q;
  assign misaligned_err  = misErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized transaction-level bench for mem_stage: each instruction is scored
// from its access kind, alignment and memory latency.
module tb_mem_stage;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult, ReadDataRF1, dmem_rdata;
  logic [4:0]  WriteRegister;
  logic        RegWrite, MemRead, MemWrite, MemToReg, dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, bus_err, misaligned_err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        RegWriteWB, MemToRegWB;
  logic [31:0] MemReadDataWB, ALUResultWB;
  logic [4:0]  WriteRegisterWB;

  int numCompared   = 0;
  int numMismatched = 0;

  // Reference state of the MEM/WB register
  logic        expRw, expM2r;
  logic [31:0] expRd, expAlu;
  logic [4:0]  expWreg;

  mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ALUResult(ALUResult), .ReadDataRF1(ReadDataRF1), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .bus_err(bus_err), .misaligned_err(misaligned_err),
    .RegWriteWB(RegWriteWB), .MemToRegWB(MemToRegWB), .MemReadDataWB(MemReadDataWB),
    .ALUResultWB(ALUResultWB), .WriteRegisterWB(WriteRegisterWB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkWb(input string tag);
    checkOutput({tag, ".RegWriteWB"},      RegWriteWB,      expRw);
    checkOutput({tag, ".MemToRegWB"},      MemToRegWB,      expM2r);
    checkOutput({tag, ".MemReadDataWB"},   MemReadDataWB,   expRd);
    checkOutput({tag, ".ALUResultWB"},     ALUResultWB,     expAlu);
    checkOutput({tag, ".WriteRegisterWB"}, WriteRegisterWB, {27'd0, expWreg});
  endtask

  // One instruction held until it retires; lat = number of req cycles before ack.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] wreg, input logic rw, input logic m2r,
                               input logic [31:0] rdata, input int lat);
    logic isAccess, isAligned, isLoad, completed;
    int   k;
    bit   done;
    isAccess  = rd | wr;
    isAligned = (addr[1:0] == 2'b00);
    isLoad    = rd & ~wr;
    MemRead = rd; MemWrite = wr; ALUResult = addr; ReadDataRF1 = wdata;
    WriteRegister = wreg; RegWrite = rw; MemToReg = m2r; dmem_rdata = rdata;
    k = 0;
    done = 0;
    while (!done && k <= T + 1) begin
      dmem_ack = isAccess && isAligned && (k == lat);
      @(negedge clk);
      checkOutput({tag, ".req"},   dmem_req,  isAccess && isAligned);
      checkOutput({tag, ".stall"}, mem_stall, isAccess && isAligned && k < lat && k < T);
      if (isAccess && isAligned) begin
        checkOutput({tag, ".we"},    dmem_we,    wr);
        checkOutput({tag, ".addr"},  dmem_addr,  addr);
        checkOutput({tag, ".wdata"}, dmem_wdata, wdata);
      end
      @(posedge clk); #1;
      done = !(isAccess && isAligned) || k == lat || k == T;
      if (!done) begin
        checkOutput({tag, ".bubbleRw"},  RegWriteWB,     1'b0);
        checkOutput({tag, ".bubbleM2r"}, MemToRegWB,     1'b0);
        checkOutput({tag, ".busErrEarly"}, bus_err,      1'b0);
        checkOutput({tag, ".misErrEarly"}, misaligned_err, 1'b0);
        k++;
      end
    end
    dmem_ack = 1'b0;
    if (!done) checkOutput({tag, ".retireBound"}, 32'd0, 32'd1);
    completed = !isAccess || (isAligned && lat <= T);
    if (completed) begin
      expRw = rw; expM2r = m2r; expAlu = addr; expWreg = wreg;
      if (isAccess && isLoad) expRd = rdata;
    end else begin
      expRw = 1'b0; expM2r = 1'b0;
    end
    checkWb(tag);
    checkOutput({tag, ".busErr"}, bus_err,        isAccess && isAligned && lat > T);
    checkOutput({tag, ".misErr"}, misaligned_err, isAccess && !isAligned);
  endtask

  initial begin
    rst = 1'b1;
    {MemRead, MemWrite, RegWrite, MemToReg, dmem_ack} = '0;
    ALUResult = '0; ReadDataRF1 = '0; WriteRegister = '0; dmem_rdata = '0;
    {expRw, expM2r} = '0; expRd = '0; expAlu = '0; expWreg = '0;
    #12;
    checkWb("reset");
    checkOutput("reset.req",    dmem_req,       1'b0);
    checkOutput("reset.stall",  mem_stall,      1'b0);
    checkOutput("reset.busErr", bus_err,        1'b0);
    checkOutput("reset.misErr", misaligned_err, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("zeroWaitLoad", 1, 0, 32'h100, 32'h0, 5'd5, 1, 1, 32'hDEADBEEF, 0);
    applyStimulus("store3",       0, 1, 32'h40, 32'h12345678, 5'd0, 0, 0, 32'h0, 3);
    applyStimulus("load2",        1, 0, 32'h80, 32'h0, 5'd7, 1, 1, 32'hCAFEF00D, 2);
    applyStimulus("timeout",      1, 0, 32'h84, 32'h0, 5'd9, 1, 1, 32'h11111111, T + 5);
    applyStimulus("misaligned",   0, 1, 32'h102, 32'hAAAA5555, 5'd0, 0, 0, 32'h0, 0);
    applyStimulus("misaligned2",  1, 0, 32'h203, 32'h0, 5'd3, 1, 1, 32'h0, 0);
    applyStimulus("ackAtTimeout", 1, 0, 32'h88, 32'h0, 5'd4, 1, 1, 32'h2222AAAA, T);
    applyStimulus("aluOp",        0, 0, 32'h55AA55AA, 32'h0, 5'd12, 1, 0, 32'h0, 0);

    // Reset while a load sits in WAIT, with the instruction withdrawn at the same time
    MemRead = 1; ALUResult = 32'h200; WriteRegister = 5'd6; RegWrite = 1; MemToReg = 1;
    dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    {MemRead, MemWrite, RegWrite, MemToReg} = '0;
    ALUResult = '0; WriteRegister = '0;
    #1;
    {expRw, expM2r} = '0; expRd = '0; expAlu = '0; expWreg = '0;
    checkWb("midWaitReset");
    checkOutput("midWaitReset.req",   dmem_req,  1'b0);
    checkOutput("midWaitReset.stall", mem_stall, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("afterReset",  0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0);
    applyStimulus("afterResetLd", 1, 0, 32'h300, 32'h0, 5'd8, 1, 1, 32'h0BADCAFE, 0);

    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [31:0] addr;
      int          lat;
      op   = 2'($urandom_range(0, 3));
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) lat = $urandom_range(T - 1, T + 3);
      else lat = $urandom_range(0, 4);
      applyStimulus("random", op[0], op[1], addr, $urandom, 5'($urandom),
                    1'($urandom), 1'($urandom), $urandom, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Consumes the EX/MEM pipeline register outputs and runs load/store transactions to the data memory over a variable-latency req/ack handshake.
- Stalls the upstream pipeline while a transaction is pending.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT without dmem_ack before the transaction is aborted as a bus error (>=1).
- CNT_W, 5, wait-counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ALUResult  in  32  effective address, or result passed to WB.
- ReadDataRF1  in  32  store data.
- WriteRegister  in  5  destination register.
- RegWrite, MemRead, MemWrite, MemToReg  in  1 each  control from EX/MEM.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word address (= ALUResult).
- dmem_wdata  out  32  = ReadDataRF1.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  transaction complete.
- mem_stall  out  1  upstream (PC, IF/ID, ID/EX, EX/MEM) must hold.
- bus_err  out  1  one-cycle pulse on timeout.
- misaligned_err  out  1  one-cycle pulse on misaligned access.
- RegWriteWB, MemToRegWB  out  1 each  MEM/WB control.
- MemReadDataWB, ALUResultWB  out  32 each  MEM/WB data.
- WriteRegisterWB  out  5  MEM/WB destination.

Behaviour:
- Definitions:
  - access = MemRead | MemWrite.
  - aligned = (ALUResult[1:0] == 0).
  - MemRead and MemWrite both high is treated as a write.
- FSM states: IDLE and WAIT. Wait counter cnt is valid in WAIT only.
- dmem_req (combinational) = (IDLE & access & aligned) | WAIT.
- dmem_we = MemWrite. dmem_addr and dmem_wdata pass through combinationally.
- mem_stall (combinational) = dmem_req & ~dmem_ack & ~timeout.
  - timeout = WAIT & (cnt == TIMEOUT_CYCLES-1).
- IDLE transitions:
  - access & aligned & dmem_ack → zero-wait completion: stay IDLE; MEM/WB captures at this edge.
  - access & aligned & ~dmem_ack → go to WAIT, cnt = 0.
  - access & ~aligned → no request, no stall. misaligned_err = 1 next cycle. MEM/WB loads a bubble.
  - ~access → MEM/WB captures the instruction (ALU/nop path); no stall.
- WAIT transitions:
  - dmem_ack → go to IDLE; MEM/WB captures the instruction; stall drops this cycle.
  - timeout (and no ack) → go to IDLE; req drops next cycle; bus_err = 1 next cycle; MEM/WB loads a bubble; stall drops this cycle.
  - ack and timeout in the same cycle → ack wins (normal completion).
  - otherwise cnt++.
- MEM/WB capture:
  - RegWriteWB <= RegWrite, MemToRegWB <= MemToReg.
  - MemReadDataWB <= dmem_rdata on a load, else holds.
  - ALUResultWB <= ALUResult, WriteRegisterWB <= WriteRegister.
- MEM/WB bubble (every stall cycle, misaligned access, or timeout):
  - RegWriteWB = 0, MemToRegWB = 0.
  - Data fields hold their previous values.
  - Prevents double write-back.
- Inputs are held stable by upstream while mem_stall = 1. A store acknowledged is complete; it is never reissued.
- Latency: one clock from completion to the WB outputs. A load with N wait cycles adds N stall cycles.
- Reset (asynchronous, any state, including mid-WAIT):
  - state = IDLE, cnt = 0, all registered outputs = 0.
  - dmem_req and mem_stall go low immediately if no access is present.
  - An in-flight transaction is abandoned; memory must tolerate req dropping without ack.
- Error pulses are registered and last exactly one cycle; back-to-back errors give back-to-back pulses.

Test Plan:
- Zero-wait load: MemRead=1, ALUResult=0x100, ack same cycle with rdata 0xDEADBEEF, RegWrite=1, WriteRegister=5, MemToReg=1 → mem_stall never 1; next edge MemReadDataWB=0xDEADBEEF, WriteRegisterWB=5, RegWriteWB=1.
- 3-wait store: MemWrite=1, addr 0x40, ReadDataRF1=0x12345678, ack on 4th req cycle → req, we=1, wdata=0x12345678 held 4 cycles; mem_stall high 3 cycles; RegWriteWB=0 throughout; exactly one acked write.
- Load wait + bubble: MemRead=1 with ack after 2 cycles → RegWriteWB=0 for 2 cycles, then 1 with captured data for one cycle; no duplicate write-back.
- Timeout: MemRead=1, ack never, TIMEOUT_CYCLES=16 → stall high 16 cycles; req drops on cycle 17; bus_err pulses once; RegWriteWB stays 0.
- Misaligned: MemWrite=1, ALUResult=0x102 → dmem_req never 1; mem_stall 0; misaligned_err = 1 for one cycle; RegWriteWB=0.
- Reset mid-WAIT: rst asserted on cycle 2 of a pending load → req, stall, and all WB outputs go 0 without a clock edge; after release with ~access, FSM in IDLE and no error pulses.
